// File: rtl/fp_arb_pkg.sv
// Shared types and defaults for the FP multiplier round-robin arbiter.
package fp_arb_pkg;
  localparam int FP_W        = 32;
  localparam int DEF_NREQ    = 4;
  localparam int DEF_TIMEOUT = 1024;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_RESP
  } state_e;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);
  logic [IDW:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int off = 0; off < NREQ; off++) begin
      // One extra bit so ptr+offset cannot overflow before the wrap.
      cand = (IDW+1)'(ptr_i) + (IDW+1)'(off);
      if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
      if (!any_o && req_i[cand[IDW-1:0]]) begin
        any_o = 1'b1;
        idx_o = cand[IDW-1:0];
        gnt_o[cand[IDW-1:0]] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fp_mul_arbiter.sv
// Shares one start/done FP multiplier between NREQ requesters, one job at a time.
module fp_mul_arbiter
  import fp_arb_pkg::*;
#(
  parameter int NREQ    = DEF_NREQ,
  parameter int IDW     = $clog2(NREQ),
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*FP_W-1:0] req_a,
  input  logic [NREQ*FP_W-1:0] req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [FP_W-1:0]      rsp_result,
  output logic                 rsp_err,
  output logic                 busy,
  output logic [FP_W-1:0]      mul_a,
  output logic [FP_W-1:0]      mul_b,
  output logic                 mul_start,
  input  logic                 mul_done,
  input  logic [FP_W-1:0]      mul_result
);
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  state_e          state_q;
  logic [IDW-1:0]  rr_ptr_q;
  logic [IDW-1:0]  cur_id_q;
  logic [TW-1:0]   to_cnt_q;
  logic [FP_W-1:0] mul_a_q, mul_b_q;
  logic [IDW-1:0]  rsp_id_q;
  logic [FP_W-1:0] rsp_result_q;
  logic            rsp_err_q;

  logic [FP_W-1:0] a_arr [NREQ];
  logic [FP_W-1:0] b_arr [NREQ];
  logic [NREQ-1:0] pick_gnt;
  logic [IDW-1:0]  pick_idx;
  logic            pick_any;
  logic            timed_out;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign a_arr[gi] = req_a[FP_W*gi +: FP_W];
      assign b_arr[gi] = req_b[FP_W*gi +: FP_W];
    end
  endgenerate

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign timed_out = (to_cnt_q == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      cur_id_q     <= '0;
      to_cnt_q     <= '0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            mul_a_q  <= a_arr[pick_idx];
            mul_b_q  <= b_arr[pick_idx];
            cur_id_q <= pick_idx;
            state_q  <= ST_START;
          end
        end
        ST_START: begin
          to_cnt_q <= '0;
          state_q  <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          to_cnt_q <= to_cnt_q + 1'b1;
          // Seeing the multiplier leave idle wins over a coincident timeout.
          if (!mul_done) begin
            state_q <= ST_WAIT_DONE;
          end else if (timed_out) begin
            rsp_id_q     <= cur_id_q;
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b1;
            state_q      <= ST_RESP;
          end
        end
        ST_WAIT_DONE: begin
          to_cnt_q <= to_cnt_q + 1'b1;
          if (mul_done) begin
            rsp_id_q     <= cur_id_q;
            rsp_result_q <= mul_result;
            rsp_err_q    <= 1'b0;
            state_q      <= ST_RESP;
          end else if (timed_out) begin
            rsp_id_q     <= cur_id_q;
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b1;
            state_q      <= ST_RESP;
          end
        end
        ST_RESP: begin
          rr_ptr_q <= (cur_id_q == IDW'(NREQ - 1)) ? '0 : cur_id_q + 1'b1;
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Grant is the only combinational output; rst_n gates it so reset forces all outputs low.
  assign req_ready  = (state_q == ST_IDLE && rst_n) ? pick_gnt : '0;
  assign mul_start  = (state_q == ST_START);
  assign rsp_valid  = (state_q == ST_RESP);
  assign busy       = (state_q != ST_IDLE);
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_err    = rsp_err_q;
endmodule

// File: doc/fp_mul_arbiter.md
# fp_mul_arbiter

Round-robin scheduler that shares the single sequential single-precision FP multiplier (start/done handshake unit) between `NREQ` independent requesters. It accepts one operand pair at a time, latches it, and sequences the multiplier's start pulse and done wait. It returns the result tagged with the requester index and flags a hung multiplier via a timeout. It sits between the requesting datapaths and the multiplier top-level.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `IDW`, `$clog2(NREQ)`: requester index width.
- `TIMEOUT`, 1024: max cycles spent waiting on the multiplier before aborting (≥ 4).
- `clk`  in  1  rising-edge clock; the only clock.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req_valid`  in  NREQ  per-requester request; held until its `req_ready` bit pulses.
- `req_a`, `req_b`  in  NREQ×32  per-requester operands (packed, requester i at [32i+31:32i]).
- `req_ready`  out  NREQ  one-hot, one-cycle accept pulse.
- `rsp_valid`  out  1  one-cycle result strobe.
- `rsp_id`  out  IDW  requester that owns the result.
- `rsp_result`  out  32  product (0 when `rsp_err`).
- `rsp_err`  out  1  qualifies `rsp_valid`: multiplier timed out.
- `busy`  out  1  high in every state except IDLE.
- `mul_a`, `mul_b`  out  32  operands to the multiplier, registered, stable from accept until RESP.
- `mul_start`  out  1  start pulse to the multiplier.
- `mul_done`  in  1  multiplier done/idle level (high while the multiplier is idle).
- `mul_result`  in  32  multiplier result, valid while `mul_done` is high after a run.

## Operation
- FSM states and transitions:
  - IDLE → START: when any `req_valid`. The grant goes to the first set bit at or after `rr_ptr`, wrapping. Pulse `req_ready[g]`, latch `req_a[g]`/`req_b[g]` into `mul_a`/`mul_b`, latch `g` into `cur_id`.
  - START → WAIT_BUSY: `mul_start`=1 for exactly this cycle.
  - WAIT_BUSY → WAIT_DONE: when `mul_done`=0, i.e. the multiplier has left idle.
  - WAIT_DONE → RESP: when `mul_done`=1. Capture `mul_result` into `rsp_result`, `rsp_err`=0.
  - WAIT_BUSY/WAIT_DONE → RESP: when `to_cnt` = `TIMEOUT-1`. `rsp_result`=0, `rsp_err`=1.
  - RESP → IDLE: `rsp_valid`=1 for this cycle. `rr_ptr` ← (`cur_id`+1) mod `NREQ`.
- `to_cnt` clears on entry to WAIT_BUSY and counts through both wait states.
- `req_valid` is sampled only in IDLE. Requests arriving during a job wait; no queueing beyond the requesters' own holding.
- Simultaneous requests: exactly one grant per job; ties are resolved by rotation. No requester waits more than `NREQ-1` jobs.
- `req_valid` dropped before its accept: ignored, no side effect.
- `mul_a`/`mul_b` do not change between the accept and the end of RESP. This is required because the multiplier loads its operands several cycles after start.
- `rsp_id`/`rsp_result`/`rsp_err` hold their last values until the next RESP.
- Reset (any state, asynchronous): state=IDLE, `rr_ptr`=0, `to_cnt`=0. All outputs are 0: `req_ready`, `rsp_*`, `busy`, `mul_a`, `mul_b`, `mul_start`. A job in flight is discarded with no response.

## Timing
- Accept at cycle 0, `mul_start` at cycle 1.
- For a multiplier that drops `mul_done` at k cycles and restores it at k+L cycles after start, `rsp_valid` asserts at cycle k+L+2.
- Minimum accept-to-accept spacing: RESP plus one IDLE cycle. Back-to-back jobs are separated by ≥1 IDLE cycle.
- Outputs are registered or decoded from state only; no combinational path from `req_valid` to `mul_*`. `req_ready` is decoded from the IDLE grant and may depend combinationally on `req_valid`.
- Timeout response at cycle `TIMEOUT`+2 after accept.

## Structure
- Package `fp_arb_pkg`:
  - state enum (IDLE, START, WAIT_BUSY, WAIT_DONE, RESP),
  - default `NREQ`/`TIMEOUT`,
  - FP word width constant (32).
- Sub-module `rr_pick`: combinational round-robin picker (`NREQ`-bit request, `IDW` pointer → one-hot grant, index, any). It is reused by other shared-unit arbiters.
- The top holds the FSM, operand/result registers, pointer and timeout counter.

## Test plan
- Bench stub multiplier: honours the start/done protocol with configurable k/L and returns `mul_a`+`mul_b` (integer), so routing is checkable.
- Single request: req 1 with A=0x40400000, B=0x40000000, k=1, L=5. Expect `req_ready`=0010 at cycle 0, one `mul_start`, `rsp_valid` at cycle 8, `rsp_id`=1, result 0x80400000, `rsp_err`=0.
- All four request together, held: grants in order 0, 1, 2, 3. Each `rsp_id` matches its grant, each result is the matching sum. Four `rsp_valid` pulses total.
- Fairness: requesters 0 and 2 continuously valid. Grants alternate 0, 2, 0, 2; requester 0 is never granted twice in a row.
- Timeout with `TIMEOUT`=16: the stub never drops `mul_done`. Expect `rsp_valid` with `rsp_err`=1 and `rsp_result`=0 at cycle 18 after accept, then return to IDLE and a normal next job.
- Reset mid-job: assert `rst_n`=0 during WAIT_DONE. All outputs are 0 immediately (asynchronously) and no `rsp_valid` follows. After release, a new request completes normally with `rr_ptr` restarted at 0.
